// File: rtl/spad_mem_responder_if.sv
// Bus bundle between the systolic-array controller / host and the scratchpad responder.
// Carries the controller ren/wen/address bus, read return, host write port and status.
// master = requester side (controller + host + debug), slave = the scratchpad itself.
interface spad_mem_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // controller request bus
  logic              ren;
  logic              wen;
  logic [ADDR_W-1:0] address_i;
  logic [DATA_W-1:0] wdata_i;
  // read return
  logic [DATA_W-1:0] rdata_o;
  logic              rvalid_o;
  logic [ADDR_W-1:0] raddr_o;
  // host preload / debug write port
  logic              host_valid;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  // status
  logic              err_clr;
  logic              err_o;
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;

  modport master (
    output ren, wen, address_i, wdata_i,
    output host_valid, host_addr, host_wdata,
    output err_clr,
    input  rdata_o, rvalid_o, raddr_o,
    input  host_ready,
    input  err_o, rd_count, wr_count
  );

  modport slave (
    input  ren, wen, address_i, wdata_i,
    input  host_valid, host_addr, host_wdata,
    input  err_clr,
    output rdata_o, rvalid_o, raddr_o,
    output host_ready,
    output err_o, rd_count, wr_count
  );
endinterface

// File: rtl/spad_mem_responder.sv
// Single-port scratchpad serving the systolic-array controller's ren/wen bus, plus host writes.
// Read latency RD_LAT cycles from issue edge to rvalid_o; writes commit at the issue edge.
// No backpressure on the controller; host writes only accepted when the controller bus is idle.
module spad_mem_responder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  spad_mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH expressed one bit wider than an address so the range compare never truncates
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [15:0]     CNT_MAX   = 16'hFFFF;

  // storage: deliberately not reset so preloaded contents survive a controller reset
  logic [DATA_W-1:0] mem [DEPTH];

  // per-cycle request decode
  logic              ctl_in_range;
  logic              host_in_range;
  logic              bus_idle;
  logic              rd_issue;
  logic              rd_ok;
  logic              ctl_wr;
  logic              host_wr;
  logic              wr_commit;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;
  logic              err_set;

  // read return pipeline, stage RD_LAT-1 drives the outputs
  logic [RD_LAT-1:0] pipe_vld;
  logic [DATA_W-1:0] pipe_dat  [RD_LAT];
  logic [ADDR_W-1:0] pipe_addr [RD_LAT];

  // status state
  logic        err;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  // classify this cycle's controller/host activity and pick the single write (if any)
  always_comb begin
    ctl_in_range  = ({1'b0, bus.address_i} < DEPTH_LIM);
    host_in_range = ({1'b0, bus.host_addr} < DEPTH_LIM);
    bus_idle      = !(bus.ren || bus.wen);

    // a simultaneous ren+wen is treated as a write only; the read is suppressed
    rd_issue  = bus.ren && !bus.wen;
    rd_ok     = rd_issue && ctl_in_range;
    ctl_wr    = bus.wen && ctl_in_range;
    host_wr   = bus_idle && bus.host_valid && host_in_range;
    wr_commit = ctl_wr || host_wr;

    wr_idx  = '0;
    wr_word = '0;
    if (ctl_wr) begin
      wr_idx  = bus.address_i[IDX_W-1:0];
      wr_word = bus.wdata_i;
    end else if (host_wr) begin
      wr_idx  = bus.host_addr[IDX_W-1:0];
      wr_word = bus.host_wdata;
    end

    // out-of-range reads still return a valid beat, carrying zero data
    rd_word = '0;
    if (rd_ok) begin
      rd_word = mem[bus.address_i[IDX_W-1:0]];
    end

    err_set = (rd_issue && !ctl_in_range)
           || (bus.wen && !ctl_in_range)
           || (bus.ren && bus.wen)
           || (bus_idle && bus.host_valid && !host_in_range);
  end

  // memory write port; reads never coincide with a write so old/new data ordering is moot
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem[wr_idx] <= wr_word;
    end
  end

  // read pipeline: capture at the issue edge, then shift one stage per cycle with no stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_dat[i]  <= '0;
        pipe_addr[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= rd_issue;
      pipe_dat[0]  <= rd_word;
      pipe_addr[0] <= rd_issue ? bus.address_i : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_dat[i]  <= pipe_dat[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  // sticky error flag; a new error in the clearing cycle wins over the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= (err && !bus.err_clr) || err_set;
    end
  end

  // saturating access counters; at most one write can commit per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_ok && (rd_cnt != CNT_MAX)) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
      if (wr_commit && (wr_cnt != CNT_MAX)) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
    end
  end

  assign bus.host_ready = bus_idle;
  assign bus.rvalid_o   = pipe_vld[RD_LAT-1];
  assign bus.rdata_o    = pipe_dat[RD_LAT-1];
  assign bus.raddr_o    = pipe_addr[RD_LAT-1];
  assign bus.err_o      = err;
  assign bus.rd_count   = rd_cnt;
  assign bus.wr_count   = wr_cnt;

endmodule

// File: tb/tb_spad_mem_responder.sv
// Bench for spad_mem_responder: scoreboard of expected read beats (data, tag, arrival cycle).
// Scenario tasks drive the bus and check status inline; a negedge monitor pops the scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_spad_mem_responder;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int RD_LAT = 2;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   exp_rd = 0;
  int   exp_wr = 0;

  exp_t              sb [$];
  logic [DATA_W-1:0] model [DEPTH];

  spad_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  spad_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // read-return monitor: every rvalid beat must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.rvalid_o === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_rvalid: got raddr=%0d rdata=%0d at cycle %0d, expected no beat",
                 bus.raddr_o, bus.rdata_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.rdata_o !== e.data || bus.raddr_o !== e.addr || cyc !== e.cyc)
          $display("FAIL read_beat: got addr=%0d data=%0d cyc=%0d, expected addr=%0d data=%0d cyc=%0d",
                   bus.raddr_o, bus.rdata_o, cyc, e.addr, e.data, e.cyc);
        else
          passes++;
      end
    end
  end

  // ---------------- drive helpers (no checking) ----------------
  task automatic idle();
    @(posedge clk); #1;
    bus.ren = 1'b0; bus.wen = 1'b0; bus.host_valid = 1'b0; bus.err_clr = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    exp_t e;
    @(posedge clk); #1;
    bus.ren = 1'b1; bus.wen = 1'b0; bus.host_valid = 1'b0; bus.err_clr = 1'b0;
    bus.address_i = a;
    e.addr = a;
    e.data = (a < DEPTH) ? model[a[5:0]] : '0;
    e.cyc  = cyc + RD_LAT;
    sb.push_back(e);
    if (a < DEPTH) exp_rd++;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    bus.ren = 1'b0; bus.wen = 1'b1; bus.host_valid = 1'b0; bus.err_clr = 1'b0;
    bus.address_i = a; bus.wdata_i = d;
    if (a < DEPTH) begin
      model[a[5:0]] = d;
      exp_wr++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0)
      $display("FAIL drain: %0d read beats still outstanding, expected 0", sb.size());
    else
      passes++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.rvalid_o !== 1'b0) $display("FAIL rst_rvalid: got %b, expected 0", bus.rvalid_o); else passes++;
    checks++; if (bus.rdata_o !== '0) $display("FAIL rst_rdata: got %0h, expected 0", bus.rdata_o); else passes++;
    checks++; if (bus.raddr_o !== '0) $display("FAIL rst_raddr: got %0h, expected 0", bus.raddr_o); else passes++;
    checks++; if (bus.err_o !== 1'b0) $display("FAIL rst_err: got %b, expected 0", bus.err_o); else passes++;
    checks++; if (bus.rd_count !== 16'd0) $display("FAIL rst_rd_count: got %0d, expected 0", bus.rd_count); else passes++;
    checks++; if (bus.wr_count !== 16'd0) $display("FAIL rst_wr_count: got %0d, expected 0", bus.wr_count); else passes++;
    checks++; if (bus.host_ready !== 1'b1) $display("FAIL rst_host_ready: got %b, expected 1", bus.host_ready); else passes++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_preload_burst();
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #1;
      bus.ren = 1'b0; bus.wen = 1'b0; bus.err_clr = 1'b0;
      bus.host_valid = 1'b1; bus.host_addr = ADDR_W'(i); bus.host_wdata = DATA_W'(i * 3);
      #1;
      checks++;
      if (bus.host_ready !== 1'b1) $display("FAIL preload_ready[%0d]: got %b, expected 1", i, bus.host_ready);
      else passes++;
      model[i] = DATA_W'(i * 3);
      exp_wr++;
    end
    for (int a = 1; a <= 32; a++) rd(ADDR_W'(a));
    idle();
    drain();
    checks++; if (bus.rd_count !== 16'(exp_rd)) $display("FAIL burst_rd_count: got %0d, expected %0d", bus.rd_count, exp_rd); else passes++;
    checks++; if (bus.wr_count !== 16'(exp_wr)) $display("FAIL burst_wr_count: got %0d, expected %0d", bus.wr_count, exp_wr); else passes++;
    checks++; if (bus.err_o !== 1'b0) $display("FAIL burst_err: got %b, expected 0", bus.err_o); else passes++;
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 16; i++) wr(ADDR_W'(32 + i), DATA_W'(100 + i));
    for (int i = 0; i < 16; i++) rd(ADDR_W'(32 + i));
    wr(ADDR_W'(33), 32'd555);
    rd(ADDR_W'(33));
    idle();
    drain();
    checks++; if (bus.wr_count !== 16'(exp_wr)) $display("FAIL wr_wr_count: got %0d, expected %0d", bus.wr_count, exp_wr); else passes++;
    checks++; if (bus.rd_count !== 16'(exp_rd)) $display("FAIL wr_rd_count: got %0d, expected %0d", bus.rd_count, exp_rd); else passes++;
  endtask

  task automatic test_rw_conflict();
    @(posedge clk); #1;
    bus.ren = 1'b1; bus.wen = 1'b1; bus.address_i = ADDR_W'(5); bus.wdata_i = 32'd7;
    model[5] = 32'd7;
    exp_wr++;
    idle();
    checks++; if (bus.err_o !== 1'b1) $display("FAIL conflict_err: got %b, expected 1", bus.err_o); else passes++;
    checks++; if (bus.wr_count !== 16'(exp_wr)) $display("FAIL conflict_wr_count: got %0d, expected %0d", bus.wr_count, exp_wr); else passes++;
    @(posedge clk); #1;
    bus.err_clr = 1'b1;
    idle();
    checks++; if (bus.err_o !== 1'b0) $display("FAIL err_clear: got %b, expected 0", bus.err_o); else passes++;
    // an error arriving in the clearing cycle must keep the flag set
    @(posedge clk); #1;
    bus.wen = 1'b1; bus.address_i = ADDR_W'(70); bus.wdata_i = 32'd9; bus.err_clr = 1'b1;
    idle();
    checks++; if (bus.err_o !== 1'b1) $display("FAIL err_set_clr: got %b, expected 1", bus.err_o); else passes++;
    checks++; if (bus.wr_count !== 16'(exp_wr)) $display("FAIL oor_wr_count: got %0d, expected %0d", bus.wr_count, exp_wr); else passes++;
    @(posedge clk); #1;
    bus.err_clr = 1'b1;
    idle();
    rd(ADDR_W'(5));
    idle();
    drain();
    checks++; if (bus.err_o !== 1'b0) $display("FAIL conflict_err_end: got %b, expected 0", bus.err_o); else passes++;
  endtask

  task automatic test_out_of_range();
    int rd_before;
    rd_before = exp_rd;
    rd(ADDR_W'(64));
    idle();
    drain();
    checks++; if (bus.err_o !== 1'b1) $display("FAIL oor_err: got %b, expected 1", bus.err_o); else passes++;
    checks++; if (bus.rd_count !== 16'(rd_before)) $display("FAIL oor_rd_count: got %0d, expected %0d", bus.rd_count, rd_before); else passes++;
    @(posedge clk); #1;
    bus.err_clr = 1'b1;
    idle();
  endtask

  task automatic test_host_blocked();
    int wr_before;
    exp_t e;
    wr_before = exp_wr;
    for (int a = 0; a < 4; a++) begin
      @(posedge clk); #1;
      bus.ren = 1'b1; bus.wen = 1'b0; bus.address_i = ADDR_W'(a);
      bus.host_valid = 1'b1; bus.host_addr = ADDR_W'(10); bus.host_wdata = 32'd999;
      e.addr = ADDR_W'(a); e.data = model[a]; e.cyc = cyc + RD_LAT;
      sb.push_back(e);
      exp_rd++;
      #1;
      checks++;
      if (bus.host_ready !== 1'b0) $display("FAIL host_ready_busy[%0d]: got %b, expected 0", a, bus.host_ready);
      else passes++;
    end
    @(posedge clk); #1;
    bus.ren = 1'b0;
    #1;
    checks++; if (bus.host_ready !== 1'b1) $display("FAIL host_ready_idle: got %b, expected 1", bus.host_ready); else passes++;
    checks++; if (bus.wr_count !== 16'(wr_before)) $display("FAIL host_blocked_wr_count: got %0d, expected %0d", bus.wr_count, wr_before); else passes++;
    model[10] = 32'd999;
    exp_wr++;
    idle();
    checks++; if (bus.wr_count !== 16'(exp_wr)) $display("FAIL host_accept_wr_count: got %0d, expected %0d", bus.wr_count, exp_wr); else passes++;
    rd(ADDR_W'(10));
    idle();
    drain();
  endtask

  task automatic test_reset_in_flight();
    int seen = 0;
    // two reads issued without expectations: reset must swallow both
    @(posedge clk); #1;
    bus.ren = 1'b1; bus.wen = 1'b0; bus.address_i = ADDR_W'(1);
    @(posedge clk); #1;
    bus.address_i = ADDR_W'(2);
    @(posedge clk); #1;
    bus.ren = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rvalid_o !== 1'b0) seen++;
    end
    checks++; if (seen != 0) $display("FAIL flush_rvalid: got %0d beats after reset, expected 0", seen); else passes++;
    checks++; if (bus.rd_count !== 16'd0) $display("FAIL flush_rd_count: got %0d, expected 0", bus.rd_count); else passes++;
    checks++; if (bus.wr_count !== 16'd0) $display("FAIL flush_wr_count: got %0d, expected 0", bus.wr_count); else passes++;
    for (int a = 0; a < 48; a++) rd(ADDR_W'(a));
    idle();
    drain();
    checks++; if (bus.rd_count !== 16'(exp_rd)) $display("FAIL flush_reread_count: got %0d, expected %0d", bus.rd_count, exp_rd); else passes++;
  endtask

  initial begin
    reset = 1'b1;
    bus.ren = 1'b0; bus.wen = 1'b0; bus.address_i = '0; bus.wdata_i = '0;
    bus.host_valid = 1'b0; bus.host_addr = '0; bus.host_wdata = '0; bus.err_clr = 1'b0;
    test_reset();
    test_preload_burst();
    test_write_read();
    test_rw_conflict();
    test_out_of_range();
    test_host_blocked();
    test_reset_in_flight();
    repeat (4) idle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
